// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_negate_n.sv
// Two's-complement negation used for operand magnitudes and result sign fix-up.
module negate_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = ~value + WIDTH'(1);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, signed or unsigned.
// state | meaning
// IDLE  | waiting for ctrl_DIV
// CALC  | shift-subtract iterations running
// DONE  | result ready to register; RDY pulses on the following cycle
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_quotient,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_overflow,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_W-1:0] iter_cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic             neg_q, neg_r;
  logic             exc_q, ovf_q;

  logic             step, finish;
  logic             a_neg, b_neg;
  logic             div_by_zero, sgn_ovf, special;
  logic [WIDTH-1:0] a_inv, b_inv, a_mag, b_mag;
  logic [WIDTH-1:0] q_inv, r_inv;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   sub;
  logic             ge;

  assign a_neg       = ctrl_SIGNED & data_operandA[WIDTH-1];
  assign b_neg       = ctrl_SIGNED & data_operandB[WIDTH-1];
  assign div_by_zero = (data_operandB == '0);
  assign sgn_ovf     = ctrl_SIGNED && (data_operandA == MIN_VAL) &&
                       (data_operandB == {WIDTH{1'b1}});
  assign special     = div_by_zero | sgn_ovf;

  negate_n #(.WIDTH(WIDTH)) u_neg_a (.value(data_operandA), .result(a_inv));
  negate_n #(.WIDTH(WIDTH)) u_neg_b (.value(data_operandB), .result(b_inv));
  negate_n #(.WIDTH(WIDTH)) u_neg_q (.value(quo),           .result(q_inv));
  negate_n #(.WIDTH(WIDTH)) u_neg_r (.value(rem[WIDTH-1:0]), .result(r_inv));

  // MIN negates to itself, which is the correct unsigned magnitude 2^(WIDTH-1).
  assign a_mag = a_neg ? a_inv : data_operandA;
  assign b_mag = b_neg ? b_inv : data_operandB;

  // quo holds the not-yet-consumed dividend bits and collects quotient bits at the bottom.
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = (shifted >= {2'b00, div_mag});
  assign sub     = shifted[WIDTH:0] - {1'b0, div_mag};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ctrl_DIV) begin
      state_nxt = special ? DONE : CALC;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        CALC:    state_nxt = (iter_cnt == LAST_ITER) ? DONE : CALC;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A start in any state wins, so a pending DONE never produces its pulse.
  always_comb begin
    step   = (state == CALC) && !ctrl_DIV;
    finish = (state == DONE) && !ctrl_DIV;
    busy   = (state != IDLE) || data_resultRDY;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iter_cnt <= '0;
      rem      <= '0;
      quo      <= '0;
      div_mag  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      exc_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (ctrl_DIV) begin
      iter_cnt <= '0;
      div_mag  <= b_mag;
      exc_q    <= div_by_zero;
      ovf_q    <= sgn_ovf & ~div_by_zero;
      if (div_by_zero) begin
        quo   <= '0;
        rem   <= {1'b0, data_operandA};
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else if (sgn_ovf) begin
        quo   <= MIN_VAL;
        rem   <= '0;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        quo   <= a_mag;
        rem   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (step) begin
      iter_cnt <= iter_cnt + CNT_W'(1);
      rem      <= ge ? sub : shifted[WIDTH:0];
      quo      <= {quo[WIDTH-2:0], ge};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_quotient  <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_overflow  <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= finish;
      if (finish) begin
        data_quotient  <= neg_q ? q_inv : quo;
        data_remainder <= neg_r ? r_inv : rem[WIDTH-1:0];
        data_exception <= exc_q;
        data_overflow  <= ovf_q;
      end
    end
  end

endmodule
